// File: rtl/fb_fill_pkg.sv
// Shared types and default geometry for the framebuffer region filler.
package fb_fill_pkg;

    localparam int DEF_WIDTH   = 640;
    localparam int DEF_HEIGHT  = 480;
    localparam int DEF_COORD_W = 11;
    localparam int DEF_COLOR_W = 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FINISH
    } fill_state_t;

    typedef struct packed {
        logic [DEF_COORD_W-1:0] x;
        logic [DEF_COORD_W-1:0] y;
        logic [DEF_COLOR_W-1:0] color;
    } pixel_t;

endpackage

// File: rtl/framebuffer_region_filler_if.sv
// Request, client pass-through and framebuffer write port of the region filler.
interface framebuffer_region_filler_if #(
    parameter int COORD_W = fb_fill_pkg::DEF_COORD_W,
    parameter int COLOR_W = fb_fill_pkg::DEF_COLOR_W
);
    import fb_fill_pkg::*;

    // Handshake: start is a one-cycle request sampled only in IDLE; busy is
    // high while pixels are being issued; done pulses for one cycle when the
    // fill ends and aborted qualifies it. abort only acts during FILL.
    logic               start;
    logic               abort;
    logic [COORD_W-1:0] rect_x0;
    logic [COORD_W-1:0] rect_y0;
    logic [COORD_W-1:0] rect_x1;
    logic [COORD_W-1:0] rect_y1;
    logic [COLOR_W-1:0] fill_color;

    logic [COORD_W-1:0] client_x;
    logic [COORD_W-1:0] client_y;
    logic [COLOR_W-1:0] client_color;
    logic               client_write;

    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic [COORD_W-1:0]   x_out;
    logic [COORD_W-1:0]   y_out;
    logic [COLOR_W-1:0]   color_out;
    logic                 write_out;
    logic [2*COORD_W-1:0] pixel_count;
    fill_state_t          dbg_state;

    modport master (
        output start, abort, rect_x0, rect_y0, rect_x1, rect_y1, fill_color,
        output client_x, client_y, client_color, client_write,
        input  busy, done, aborted, x_out, y_out, color_out, write_out,
        input  pixel_count, dbg_state
    );

    modport slave (
        input  start, abort, rect_x0, rect_y0, rect_x1, rect_y1, fill_color,
        input  client_x, client_y, client_color, client_write,
        output busy, done, aborted, x_out, y_out, color_out, write_out,
        output pixel_count, dbg_state
    );

endinterface

// File: rtl/raster_cursor.sv
// Loadable x/y raster counter bounded by an inclusive rectangle.
module raster_cursor #(
    parameter int COORD_W = fb_fill_pkg::DEF_COORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               advance,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    logic [COORD_W-1:0] x0_q;
    logic [COORD_W-1:0] x1_q;
    logic [COORD_W-1:0] y1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            x    <= '0;
            y    <= '0;
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
        end else if (load) begin
            x    <= x0;
            y    <= y0;
            x0_q <= x0;
            x1_q <= x1;
            y1_q <= y1;
        end else if (advance) begin
            // End of a row wraps to the left edge of the next row.
            if (x == x1_q) begin
                x <= x0_q;
                y <= y + COORD_W'(1);
            end else begin
                x <= x + COORD_W'(1);
            end
        end
    end

    assign last = (x == x1_q) && (y == y1_q);

endmodule

// File: rtl/framebuffer_region_filler.sv
// Raster-order rectangle filler in front of the framebuffer; client writes pass through when idle.
module framebuffer_region_filler
    import fb_fill_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    parameter int COORD_W = DEF_COORD_W,
    parameter int COLOR_W = DEF_COLOR_W
) (
    input logic                        clk,
    input logic                        reset,
    framebuffer_region_filler_if.slave bus
);

    localparam logic [COORD_W-1:0]   X_MAX   = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0]   Y_MAX   = COORD_W'(HEIGHT - 1);
    localparam logic [2*COORD_W-1:0] CNT_MAX = '1;

    fill_state_t state, state_n;

    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic                 write_q, write_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic                 abort_hit_q, abort_hit_d;
    logic [2*COORD_W-1:0] count_q, count_d;
    logic [COLOR_W-1:0]   fcolor_q, fcolor_d;

    logic [COORD_W-1:0] x1_clamped;
    logic [COORD_W-1:0] y1_clamped;
    logic               rect_empty;
    logic               client_ok;
    logic               cur_load;
    logic               cur_adv;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               cur_last;

    // Clamped far edges never exceed the screen, so an off-screen near edge
    // lands on the x0 > x1 / y0 > y1 test and counts as empty.
    assign x1_clamped = (bus.rect_x1 > X_MAX) ? X_MAX : bus.rect_x1;
    assign y1_clamped = (bus.rect_y1 > Y_MAX) ? Y_MAX : bus.rect_y1;
    assign rect_empty = (bus.rect_x0 > x1_clamped) || (bus.rect_y0 > y1_clamped);
    assign client_ok  = (bus.client_x <= X_MAX) && (bus.client_y <= Y_MAX);

    raster_cursor #(
        .COORD_W (COORD_W)
    ) u_cursor (
        .clk     (clk),
        .reset   (reset),
        .load    (cur_load),
        .advance (cur_adv),
        .x0      (bus.rect_x0),
        .y0      (bus.rect_y0),
        .x1      (x1_clamped),
        .y1      (y1_clamped),
        .x       (cur_x),
        .y       (cur_y),
        .last    (cur_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            color_q     <= '0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            abort_hit_q <= 1'b0;
            count_q     <= '0;
            fcolor_q    <= '0;
        end else begin
            state       <= state_n;
            x_q         <= x_d;
            y_q         <= y_d;
            color_q     <= color_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            abort_hit_q <= abort_hit_d;
            count_q     <= count_d;
            fcolor_q    <= fcolor_d;
        end
    end

    always_comb begin
        state_n     = state;
        x_d         = x_q;
        y_d         = y_q;
        color_d     = color_q;
        write_d     = 1'b0;
        done_d      = 1'b0;
        aborted_d   = aborted_q;
        abort_hit_d = abort_hit_q;
        count_d     = count_q;
        fcolor_d    = fcolor_q;
        cur_load    = 1'b0;
        cur_adv     = 1'b0;

        case (state)
            IDLE: begin
                x_d     = bus.client_x;
                y_d     = bus.client_y;
                color_d = bus.client_color;
                write_d = bus.client_write && client_ok;
                if (bus.start) begin
                    fcolor_d    = bus.fill_color;
                    count_d     = '0;
                    aborted_d   = 1'b0;
                    abort_hit_d = 1'b0;
                    if (rect_empty) begin
                        state_n = FINISH;
                    end else begin
                        state_n  = FILL;
                        cur_load = 1'b1;
                    end
                end
            end
            FILL: begin
                if (bus.abort) begin
                    abort_hit_d = 1'b1;
                    state_n     = FINISH;
                end else begin
                    x_d     = cur_x;
                    y_d     = cur_y;
                    color_d = fcolor_q;
                    write_d = 1'b1;
                    count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
                    cur_adv = 1'b1;
                    if (cur_last) begin
                        state_n = FINISH;
                    end
                end
            end
            FINISH: begin
                done_d    = 1'b1;
                aborted_d = abort_hit_q;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_d = (state == FILL) || (state_n == FILL);
    end

    assign bus.x_out       = x_q;
    assign bus.y_out       = y_q;
    assign bus.color_out   = color_q;
    assign bus.write_out   = write_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;
    assign bus.pixel_count = count_q;
    assign bus.dbg_state   = state;

endmodule

// File: tb/tb_framebuffer_region_filler.sv
// Directed bench: client pass-through table plus scoreboarded fill sequences.
module tb_framebuffer_region_filler;
    import fb_fill_pkg::*;

    localparam int CW = DEF_COORD_W;
    localparam int PW = 2 * CW + DEF_COLOR_W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    framebuffer_region_filler_if #(.COORD_W(CW), .COLOR_W(DEF_COLOR_W)) bus ();

    framebuffer_region_filler #(
        .WIDTH   (640),
        .HEIGHT  (480),
        .COORD_W (CW),
        .COLOR_W (DEF_COLOR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    logic [PW-1:0] exp_q[$];

    typedef struct {
        int x;
        int y;
        bit c;
        bit w;
        bit exp_w;
        int exp_x;
        int exp_y;
        bit exp_c;
    } client_vec_t;

    client_vec_t cvec[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] pack(input int x, input int y, input bit c);
        pixel_t p;
        p.x = CW'(x);
        p.y = CW'(y);
        p.color = c;
        return p;
    endfunction

    task automatic idle_inputs();
        bus.start = 0;
        bus.abort = 0;
        bus.rect_x0 = '0;
        bus.rect_y0 = '0;
        bus.rect_x1 = '0;
        bus.rect_y1 = '0;
        bus.fill_color = '0;
        bus.client_x = '0;
        bus.client_y = '0;
        bus.client_color = '0;
        bus.client_write = 0;
    endtask

    // Runs one fill and scoreboards every write against the raster model.
    task automatic run_fill(input string tag, input int x0, input int y0, input int x1, input int y1,
                            input bit col, input int abort_after, input bit poke_client,
                            input bit poke_start);
        int x1c, y1c, total, n_exp, writes, first_cyc, done_cyc, exp_done_cyc;
        bit seen_done, busy_bad, will_abort, got_aborted;
        logic [31:0] got_count;
        x1c = (x1 > 639) ? 639 : x1;
        y1c = (y1 > 479) ? 479 : y1;
        exp_q.delete();
        for (int y = y0; y <= y1c; y++)
            for (int x = x0; x <= x1c; x++)
                exp_q.push_back(pack(x, y, col));
        total = exp_q.size();
        will_abort = (abort_after >= 0) && (abort_after < total);
        n_exp = will_abort ? abort_after : total;
        if (total == 0) exp_done_cyc = 1;
        else if (will_abort) exp_done_cyc = n_exp + 2;
        else exp_done_cyc = n_exp + 1;

        bus.rect_x0 = CW'(x0);
        bus.rect_y0 = CW'(y0);
        bus.rect_x1 = CW'(x1);
        bus.rect_y1 = CW'(y1);
        bus.fill_color = col;
        bus.start = 1;
        tick();
        bus.start = 0;
        check({tag, "_busy_after_start"}, bus.busy, (total > 0));

        writes = 0; first_cyc = -1; done_cyc = -1;
        seen_done = 0; busy_bad = 0; got_aborted = 0; got_count = '0;
        for (int cyc = 1; cyc <= n_exp + 8 && !seen_done; cyc++) begin
            bus.abort = will_abort && (writes == abort_after);
            if (poke_client && cyc >= 2 && cyc <= 5) begin
                bus.client_x = 11'd7;
                bus.client_y = 11'd9;
                bus.client_color = ~col;
                bus.client_write = 1;
            end
            bus.start = poke_start && (cyc == 3 || (total > 0 && writes == n_exp));
            tick();
            bus.abort = 0;
            bus.start = 0;
            bus.client_write = 0;
            if (bus.write_out) begin
                if (first_cyc < 0) first_cyc = cyc;
                writes++;
                if (exp_q.size() > 0)
                    check({tag, "_pixel"}, {bus.x_out, bus.y_out, bus.color_out}, exp_q.pop_front());
                else
                    check({tag, "_extra_write"}, 1, 0);
                if (!bus.busy) busy_bad = 1;
            end
            if (bus.done) begin
                seen_done = 1;
                done_cyc = cyc;
                got_aborted = bus.aborted;
                got_count = bus.pixel_count;
            end
        end
        exp_q.delete();

        check({tag, "_done_seen"}, seen_done, 1);
        check({tag, "_write_count"}, writes, n_exp);
        check({tag, "_done_cycle"}, done_cyc, exp_done_cyc);
        check({tag, "_aborted"}, got_aborted, will_abort);
        check({tag, "_pixel_count"}, got_count, n_exp);
        check({tag, "_busy_during_writes"}, busy_bad, 0);
        if (n_exp > 0) check({tag, "_first_write_cycle"}, first_cyc, 1);

        tick();
        check({tag, "_post_busy"}, bus.busy, 0);
        check({tag, "_post_done"}, bus.done, 0);
        check({tag, "_post_write"}, bus.write_out, 0);
        check({tag, "_post_count"}, bus.pixel_count, n_exp);
        check({tag, "_post_aborted"}, bus.aborted, will_abort);
    endtask

    initial begin
        bit done_leak;
        idle_inputs();
        reset = 1;
        repeat (3) tick();
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_aborted", bus.aborted, 0);
        check("reset_write", bus.write_out, 0);
        check("reset_xy", {bus.x_out, bus.y_out, bus.color_out}, 0);
        check("reset_count", bus.pixel_count, 0);
        reset = 0;
        tick();

        cvec[0] = '{x: 10,  y: 20,  c: 1, w: 1, exp_w: 1, exp_x: 10,  exp_y: 20,  exp_c: 1};
        cvec[1] = '{x: 640, y: 5,   c: 1, w: 1, exp_w: 0, exp_x: 640, exp_y: 5,   exp_c: 1};
        cvec[2] = '{x: 639, y: 479, c: 0, w: 1, exp_w: 1, exp_x: 639, exp_y: 479, exp_c: 0};
        cvec[3] = '{x: 5,   y: 480, c: 1, w: 1, exp_w: 0, exp_x: 5,   exp_y: 480, exp_c: 1};
        cvec[4] = '{x: 100, y: 200, c: 1, w: 0, exp_w: 0, exp_x: 100, exp_y: 200, exp_c: 1};
        cvec[5] = '{x: 0,   y: 0,   c: 0, w: 1, exp_w: 1, exp_x: 0,   exp_y: 0,   exp_c: 0};
        for (int i = 0; i < 6; i++) begin
            bus.client_x = CW'(cvec[i].x);
            bus.client_y = CW'(cvec[i].y);
            bus.client_color = cvec[i].c;
            bus.client_write = cvec[i].w;
            tick();
            check($sformatf("client%0d_write", i), bus.write_out, cvec[i].exp_w);
            check($sformatf("client%0d_x", i), bus.x_out, cvec[i].exp_x);
            check($sformatf("client%0d_y", i), bus.y_out, cvec[i].exp_y);
            check($sformatf("client%0d_color", i), bus.color_out, cvec[i].exp_c);
        end
        idle_inputs();
        tick();

        run_fill("small", 2, 3, 4, 4, 0, -1, 0, 1);
        run_fill("clamp", 630, 470, 700, 600, 1, -1, 0, 0);
        run_fill("empty_x", 5, 0, 4, 10, 1, -1, 0, 0);
        run_fill("empty_y", 0, 9, 10, 8, 1, -1, 0, 0);
        run_fill("offscreen", 700, 0, 800, 5, 1, -1, 0, 0);
        run_fill("single", 5, 5, 5, 5, 1, -1, 0, 0);
        run_fill("abort", 0, 0, 639, 479, 1, 1000, 1, 0);

        // Reset in the middle of a fill: outputs clear and no done follows.
        bus.rect_x0 = '0;
        bus.rect_y0 = '0;
        bus.rect_x1 = 11'd639;
        bus.rect_y1 = 11'd479;
        bus.fill_color = 1;
        bus.start = 1;
        tick();
        bus.start = 0;
        repeat (50) tick();
        check("midfill_writing", bus.write_out, 1);
        reset = 1;
        tick();
        reset = 0;
        check("midreset_busy", bus.busy, 0);
        check("midreset_write", bus.write_out, 0);
        check("midreset_done", bus.done, 0);
        check("midreset_xy", {bus.x_out, bus.y_out, bus.color_out}, 0);
        check("midreset_count", bus.pixel_count, 0);
        done_leak = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.done || bus.write_out || bus.busy) done_leak = 1;
        end
        check("midreset_quiet", done_leak, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
